// File: rtl/qspi_mem_arb_pkg.sv
// Shared SoC definitions for the QSPI memory arbiter: FSM state encoding and default sizing.
package qspi_mem_arb_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        GAP  = 2'd2
    } arb_state_e;

    localparam int QSPI_ADR_W      = 24;
    localparam int ARB_TIMEOUT_CYC = 1023;

endpackage

// File: rtl/qspi_mem_arb_if.sv
// Bundle of requester-side Wishbone ports and memory-controller ports around the QSPI arbiter.
interface qspi_mem_arb_if
    import qspi_mem_arb_pkg::*;
#(
    parameter int NUM_REQ = 8,
    parameter int ADR_W   = QSPI_ADR_W
);
    localparam int GNT_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    logic [NUM_REQ-1:0]       en_i;
    logic [NUM_REQ-1:0]       req_cyc_i;
    logic [NUM_REQ-1:0]       req_we_i;
    logic [NUM_REQ*ADR_W-1:0] req_adr_i;
    logic [NUM_REQ*32-1:0]    req_dat_i;
    logic [NUM_REQ*4-1:0]     req_sel_i;
    logic [NUM_REQ-1:0]       req_ack_o;
    logic [NUM_REQ-1:0]       req_err_o;
    logic [31:0]              req_dat_o;
    logic                     mem_cyc_o;
    logic                     mem_we_o;
    logic [ADR_W-1:0]         mem_adr_o;
    logic [31:0]              mem_dat_o;
    logic [3:0]               mem_sel_o;
    logic                     mem_ack_i;
    logic [31:0]              mem_dat_i;
    logic                     busy_o;
    logic [GNT_W-1:0]         grant_o;

    // Arbiter side.
    modport slave (
        input  en_i, req_cyc_i, req_we_i, req_adr_i, req_dat_i, req_sel_i, mem_ack_i, mem_dat_i,
        output req_ack_o, req_err_o, req_dat_o, mem_cyc_o, mem_we_o, mem_adr_o, mem_dat_o,
               mem_sel_o, busy_o, grant_o
    );

    // Surrounding SoC side (cores and memory controller).
    modport master (
        output en_i, req_cyc_i, req_we_i, req_adr_i, req_dat_i, req_sel_i, mem_ack_i, mem_dat_i,
        input  req_ack_o, req_err_o, req_dat_o, mem_cyc_o, mem_we_o, mem_adr_o, mem_dat_o,
               mem_sel_o, busy_o, grant_o
    );

endinterface

// File: rtl/qspi_mem_arb_rr_pick.sv
// Combinational round-robin picker: first set bit of pend searching upward from last+1, wrapping.
module rr_pick #(
    parameter int N     = 8,
    parameter int IDX_W = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]     pend,
    input  logic [IDX_W-1:0] last,
    output logic [IDX_W-1:0] idx,
    output logic             valid
);

    always_comb begin
        int unsigned cand;
        cand  = 0;
        idx   = '0;
        valid = 1'b0;
        for (int unsigned i = 1; i <= unsigned'(N); i++) begin
            cand = (32'(last) + i) % unsigned'(N);
            if (!valid && pend[IDX_W'(cand)]) begin
                idx   = IDX_W'(cand);
                valid = 1'b1;
            end
        end
    end

endmodule

// File: rtl/qspi_mem_arb.sv
// Round-robin arbiter serialising per-core Wishbone masters onto the single QSPI XIP controller,
// with enable masking, a mandatory idle gap between transactions and an ack watchdog.
module qspi_mem_arb
    import qspi_mem_arb_pkg::*;
#(
    parameter int NUM_REQ     = 8,
    parameter int ADR_W       = QSPI_ADR_W,
    parameter int TIMEOUT_CYC = ARB_TIMEOUT_CYC
) (
    input  logic           clk_i,
    input  logic           rst_i,
    qspi_mem_arb_if.slave  bus
);

    localparam int GNT_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int WD_W  = $clog2(TIMEOUT_CYC + 1);

    arb_state_e       state_q, state_d;
    logic [GNT_W-1:0] grant_q, last_q, pick_idx;
    logic             pick_valid;
    logic [WD_W-1:0]  wd_q;
    logic [NUM_REQ-1:0] pend;
    logic             in_busy, gnt_cyc, timeout, tmo_err;

    logic [ADR_W-1:0] adr_arr [NUM_REQ];
    logic [31:0]      dat_arr [NUM_REQ];
    logic [3:0]       sel_arr [NUM_REQ];

    for (genvar n = 0; n < NUM_REQ; n++) begin : g_unpack
        assign adr_arr[n] = bus.req_adr_i[n*ADR_W +: ADR_W];
        assign dat_arr[n] = bus.req_dat_i[n*32 +: 32];
        assign sel_arr[n] = bus.req_sel_i[n*4 +: 4];
    end

    assign pend = bus.req_cyc_i & bus.en_i;

    rr_pick #(
        .N     (NUM_REQ),
        .IDX_W (GNT_W)
    ) u_pick (
        .pend  (pend),
        .last  (last_q),
        .idx   (pick_idx),
        .valid (pick_valid)
    );

    assign in_busy = (state_q == BUSY);
    assign gnt_cyc = bus.req_cyc_i[grant_q];
    assign timeout = in_busy && (wd_q == WD_W'(TIMEOUT_CYC));
    // An ack landing on the watchdog limit still completes the transfer.
    assign tmo_err = timeout && !bus.mem_ack_i;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            grant_q <= '0;
            last_q  <= GNT_W'(NUM_REQ - 1);
            wd_q    <= '0;
        end else begin
            state_q <= state_d;
            if (state_q == IDLE && pick_valid) begin
                grant_q <= pick_idx;
                last_q  <= pick_idx;
                wd_q    <= '0;
            end else if (in_busy && !timeout) begin
                wd_q <= wd_q + 1'b1;
            end
        end
    end

    always_comb begin
        state_d       = state_q;
        bus.mem_cyc_o = 1'b0;
        bus.req_ack_o = '0;
        bus.req_err_o = '0;
        unique case (state_q)
            IDLE: begin
                if (pick_valid) state_d = BUSY;
            end
            BUSY: begin
                bus.req_ack_o[grant_q] = bus.mem_ack_i;
                bus.req_err_o[grant_q] = tmo_err;
                bus.mem_cyc_o          = gnt_cyc && !tmo_err;
                if (bus.mem_ack_i || !gnt_cyc || timeout) state_d = GAP;
            end
            GAP: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign bus.mem_we_o  = bus.req_we_i[grant_q];
    assign bus.mem_adr_o = adr_arr[grant_q];
    assign bus.mem_dat_o = dat_arr[grant_q];
    assign bus.mem_sel_o = sel_arr[grant_q];
    assign bus.req_dat_o = bus.mem_dat_i;
    assign bus.busy_o    = in_busy;
    assign bus.grant_o   = grant_q;

endmodule

// File: tb/tb_qspi_mem_arb.sv
// Directed bench for qspi_mem_arb: fairness, enable masking, ack path, watchdog, abort, reset.
module tb_qspi_mem_arb;
    import qspi_mem_arb_pkg::*;

    localparam int N  = 8;
    localparam int AW = 24;
    localparam int TO = 8;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    qspi_mem_arb_if #(.NUM_REQ(N), .ADR_W(AW)) bus ();

    qspi_mem_arb #(
        .NUM_REQ     (N),
        .ADR_W       (AW),
        .TIMEOUT_CYC (TO)
    ) dut (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (bus)
    );

    int unsigned n_cmp = 0;
    int unsigned n_bad = 0;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    initial begin
        #50000;
        $display("FAIL bench_timeout: got no finish expected finish");
        $fatal(1, "bench did not complete");
    end

    int unsigned order [6] = '{0, 2, 5, 0, 2, 5};

    initial begin
        bus.en_i      = '1;
        bus.req_cyc_i = '0;
        bus.req_we_i  = '0;
        bus.req_dat_i = '0;
        bus.req_sel_i = '1;
        bus.mem_ack_i = 1'b0;
        bus.mem_dat_i = '0;
        for (int n = 0; n < N; n++) bus.req_adr_i[n*AW +: AW] = AW'(32'h010000 + n);

        // Reset state
        step();
        step();
        check_eq("rst_busy",  64'(bus.busy_o),    64'(0));
        check_eq("rst_cyc",   64'(bus.mem_cyc_o), 64'(0));
        check_eq("rst_grant", 64'(bus.grant_o),   64'(0));
        check_eq("rst_ack",   64'(bus.req_ack_o), 64'(0));
        check_eq("rst_err",   64'(bus.req_err_o), 64'(0));
        rst = 1'b0;

        // Fairness: 0, 2, 5 hold cyc, memory acks in the first BUSY cycle
        bus.req_cyc_i = 8'b0010_0101;
        for (int k = 0; k < 6; k++) begin
            step();
            bus.mem_ack_i = 1'b1;
            settle();
            check_eq("fair_grant", 64'(bus.grant_o),   64'(order[k]));
            check_eq("fair_cyc",   64'(bus.mem_cyc_o), 64'(1));
            check_eq("fair_ack",   64'(bus.req_ack_o), 64'(64'd1 << order[k]));
            step();
            bus.mem_ack_i = 1'b0;
            settle();
            check_eq("fair_gap_cyc", 64'(bus.mem_cyc_o), 64'(0));
            step();
            check_eq("fair_idle_cyc", 64'(bus.mem_cyc_o), 64'(0));
        end
        bus.req_cyc_i = '0;

        // Enable mask: 2 disabled, would otherwise win from last=5
        bus.en_i      = 8'b1111_1011;
        bus.req_cyc_i = 8'b0001_0100;
        step();
        check_eq("en_grant", 64'(bus.grant_o), 64'(4));
        bus.mem_ack_i = 1'b1;
        settle();
        check_eq("en_ack", 64'(bus.req_ack_o), 64'(8'h10));
        step();
        bus.mem_ack_i    = 1'b0;
        bus.req_cyc_i[4] = 1'b0;
        settle();
        check_eq("en_gap_busy", 64'(bus.busy_o), 64'(0));
        step();
        step();
        check_eq("en_masked_busy", 64'(bus.busy_o), 64'(0));
        step();
        check_eq("en_masked_busy2", 64'(bus.busy_o),    64'(0));
        check_eq("en_masked_ack",   64'(bus.req_ack_o), 64'(0));
        bus.req_cyc_i = '0;
        bus.en_i      = '1;

        // Single requester 3, ack in 5th BUSY cycle
        bus.req_adr_i[3*AW +: AW] = 24'h000100;
        bus.req_cyc_i[3] = 1'b1;
        settle();
        check_eq("single_t0_cyc", 64'(bus.mem_cyc_o), 64'(0));
        step();
        check_eq("single_cyc",   64'(bus.mem_cyc_o), 64'(1));
        check_eq("single_adr",   64'(bus.mem_adr_o), 64'(24'h000100));
        check_eq("single_grant", 64'(bus.grant_o),   64'(3));
        for (int i = 0; i < 3; i++) begin
            step();
            check_eq("single_wait_ack", 64'(bus.req_ack_o), 64'(0));
            check_eq("single_wait_cyc", 64'(bus.mem_cyc_o), 64'(1));
        end
        step();
        bus.mem_ack_i = 1'b1;
        bus.mem_dat_i = 32'hDEADBEEF;
        settle();
        check_eq("single_ack", 64'(bus.req_ack_o), 64'(8'h08));
        check_eq("single_dat", 64'(bus.req_dat_o), 64'(32'hDEADBEEF));
        step();
        bus.mem_ack_i    = 1'b0;
        bus.req_cyc_i[3] = 1'b0;
        settle();
        check_eq("single_gap_cyc", 64'(bus.mem_cyc_o), 64'(0));
        check_eq("single_gap_ack", 64'(bus.req_ack_o), 64'(0));
        step();
        check_eq("single_idle_busy", 64'(bus.busy_o), 64'(0));

        // Watchdog: requester 1 never acked, 6 becomes pending meanwhile
        bus.req_cyc_i[1] = 1'b1;
        step();
        check_eq("to_grant", 64'(bus.grant_o), 64'(1));
        bus.req_cyc_i[6] = 1'b1;
        settle();
        check_eq("to_wait_err1", 64'(bus.req_err_o), 64'(0));
        for (int i = 0; i < 7; i++) begin
            step();
            check_eq("to_wait_err", 64'(bus.req_err_o), 64'(0));
        end
        step();
        check_eq("to_err",     64'(bus.req_err_o), 64'(8'h02));
        check_eq("to_err_cyc", 64'(bus.mem_cyc_o), 64'(0));
        check_eq("to_err_ack", 64'(bus.req_ack_o), 64'(0));
        step();
        bus.req_cyc_i[1] = 1'b0;
        settle();
        check_eq("to_gap_err",  64'(bus.req_err_o), 64'(0));
        check_eq("to_gap_busy", 64'(bus.busy_o),    64'(0));
        step();
        check_eq("to_idle_busy", 64'(bus.busy_o), 64'(0));
        step();
        check_eq("to_next_grant", 64'(bus.grant_o),   64'(6));
        check_eq("to_next_cyc",   64'(bus.mem_cyc_o), 64'(1));
        bus.mem_ack_i = 1'b1;
        settle();
        check_eq("to_next_ack", 64'(bus.req_ack_o), 64'(8'h40));
        step();
        bus.mem_ack_i    = 1'b0;
        bus.req_cyc_i[6] = 1'b0;
        step();

        // Abort: requester 7 drops cyc in its 3rd BUSY cycle
        bus.req_cyc_i[7] = 1'b1;
        step();
        check_eq("ab_grant", 64'(bus.grant_o), 64'(7));
        step();
        check_eq("ab_cyc2", 64'(bus.mem_cyc_o), 64'(1));
        step();
        bus.req_cyc_i[7] = 1'b0;
        settle();
        check_eq("ab_cyc3", 64'(bus.mem_cyc_o), 64'(0));
        check_eq("ab_ack3", 64'(bus.req_ack_o), 64'(0));
        step();
        bus.mem_ack_i = 1'b1;
        settle();
        check_eq("ab_gap_busy",  64'(bus.busy_o),    64'(0));
        check_eq("ab_stray_ack", 64'(bus.req_ack_o), 64'(0));
        bus.mem_ack_i = 1'b0;
        step();

        // Ack and watchdog limit in the same cycle; also a write through the mux
        bus.req_we_i[0]        = 1'b1;
        bus.req_dat_i[0 +: 32] = 32'hCAFEF00D;
        bus.req_sel_i[0 +: 4]  = 4'hC;
        bus.req_cyc_i[0]       = 1'b1;
        step();
        check_eq("tie_grant", 64'(bus.grant_o),   64'(0));
        check_eq("tie_we",    64'(bus.mem_we_o),  64'(1));
        check_eq("tie_dat",   64'(bus.mem_dat_o), 64'(32'hCAFEF00D));
        check_eq("tie_sel",   64'(bus.mem_sel_o), 64'(4'hC));
        for (int i = 0; i < 7; i++) step();
        step();
        bus.mem_ack_i = 1'b1;
        settle();
        check_eq("tie_ack", 64'(bus.req_ack_o), 64'(8'h01));
        check_eq("tie_err", 64'(bus.req_err_o), 64'(0));
        check_eq("tie_cyc", 64'(bus.mem_cyc_o), 64'(1));
        step();
        bus.mem_ack_i    = 1'b0;
        bus.req_cyc_i[0] = 1'b0;
        bus.req_we_i[0]  = 1'b0;
        settle();
        check_eq("tie_gap_err", 64'(bus.req_err_o), 64'(0));
        step();

        // Reset pulse during BUSY of requester 2
        bus.req_cyc_i[2] = 1'b1;
        step();
        check_eq("mr_grant", 64'(bus.grant_o), 64'(2));
        check_eq("mr_busy",  64'(bus.busy_o),  64'(1));
        rst = 1'b1;
        step();
        check_eq("mr_rst_busy",  64'(bus.busy_o),    64'(0));
        check_eq("mr_rst_cyc",   64'(bus.mem_cyc_o), 64'(0));
        check_eq("mr_rst_grant", 64'(bus.grant_o),   64'(0));
        check_eq("mr_rst_ack",   64'(bus.req_ack_o), 64'(0));
        rst = 1'b0;
        bus.req_cyc_i = 8'b0000_1001;
        step();
        check_eq("mr_rr_grant", 64'(bus.grant_o),   64'(0));
        check_eq("mr_rr_adr",   64'(bus.mem_adr_o), 64'(24'h010000));
        check_eq("mr_rr_cyc",   64'(bus.mem_cyc_o), 64'(1));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
